// File: rtl/scan_pkg.sv
// Shared constants, types and helpers for the display scan controller.
// Optional build macro: LEADING_ZERO_BLANK_EN (see display_scan_ctrl).
package scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W = 2;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [3:0] DIGIT_OFF = 4'b1111;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [IDX_W-1:0] scan_idx_t;

  typedef enum logic {
    LD_IDLE,
    LD_PEND
  } ld_state_t;

  function automatic logic [3:0] nibble_at(
    input logic [VAL_W-1:0] v,
    input scan_idx_t i
  );
    logic [3:0] n;
    n = 4'h0;
    unique case (i)
      2'd0: n = v[3:0];
      2'd1: n = v[7:4];
      2'd2: n = v[11:8];
      2'd3: n = v[15:12];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high for one cycle
// out of every SCAN_DIV cycles.
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner with load handshake.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module display_scan_ctrl
  import scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VAL_W-1:0] value_in,
  output logic             ready,
  output logic [3:0]       digit_bcd,
  output logic [3:0]       digit_en_n,
  output logic             frame_start
);

  logic             tick;
  logic             wrap;
  logic             accept;
  logic             pend_we;
  logic             disp_we;
  logic             valid;
  logic             blank;
  logic             show;
  logic [3:0]       nib;
  scan_idx_t        idx;
  logic [VAL_W-1:0] disp;
  logic [VAL_W-1:0] pend;
  ld_state_t        st;
  ld_state_t        st_nx;

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign wrap   = tick && (idx == 2'd3);
  assign ready  = (st == LD_IDLE);
  assign accept = load && ready;

  // Pending value only moves at a frame boundary,
  // so the shown value never changes mid-frame.
  always_comb begin
    st_nx   = st;
    pend_we = 1'b0;
    disp_we = 1'b0;
    unique case (st)
      LD_IDLE: begin
        if (accept) begin
          pend_we = 1'b1;
          st_nx   = LD_PEND;
        end
      end
      LD_PEND: begin
        if (wrap) begin
          disp_we = 1'b1;
          st_nx   = LD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= LD_IDLE;
      idx  <= '0;
      disp <= '0;
      pend <= '0;
    end else begin
      st <= st_nx;
      if (tick) idx <= idx + 1'b1;
      if (pend_we) pend <= value_in;
      if (disp_we) disp <= pend;
    end
  end

  assign nib   = nibble_at(disp, idx);
  assign valid = (nib <= BCD_MAX);

  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (1'b1)
      idx == 2'd3: blank = (disp[15:12] == '0);
      idx == 2'd2: blank = (disp[15:8] == '0);
      idx == 2'd1: blank = (disp[15:4] == '0);
      default:     blank = 1'b0;
    endcase
`endif
  end

  assign show = valid && !blank;

  // Enable is forced off on the index-change edge,
  // giving one dead cycle before the new digit lights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en_n  <= DIGIT_OFF;
      digit_bcd   <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      digit_bcd   <= valid ? nib : 4'h0;
      if (tick || !show) begin
        digit_en_n <= DIGIT_OFF;
      end else begin
        digit_en_n <= ~(4'b0001 << idx);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised self-checking bench for display_scan_ctrl (SCAN_DIV = 4).
module tb_display_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int FRAME = 4 * SCAN_DIV;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic        ready;
  logic        frame_start;
  logic [3:0]  digit_bcd;
  logic [3:0]  digit_en_n;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: cycles since reset release,
  // shown value, pending value, handshake flag, expected bcd.
  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_ready;
  logic [3:0]  m_bcd;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value_in   (value_in),
    .ready      (ready),
    .digit_bcd  (digit_bcd),
    .digit_en_n (digit_en_n),
    .frame_start(frame_start)
  );

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = (v >> (4 * d)) & 16'h000F;
    return s[3:0];
  endfunction

  function automatic bit shown(input logic [15:0] v, input int d);
    if (nib(v, d) > 4'd9) return 1'b0;
    if (LZB && d > 0 && (v >> (4 * d)) == 16'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [9:0] expv();
    int d;
    logic [3:0] en;
    logic fs;
    d = (k / SCAN_DIV) % 4;
    en = 4'hF;
    if (k % SCAN_DIV != 0 && shown(m_disp, d)) en = ~(4'b0001 << d);
    fs = (k > 0) && (k % FRAME == 0);
    return {m_ready, fs, en, m_bcd};
  endfunction

  function automatic logic [9:0] got();
    return {ready, frame_start, digit_en_n, digit_bcd};
  endfunction

  task automatic model_reset();
    k = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_ready = 1'b1;
    m_bcd = 4'h0;
  endtask

  task automatic step();
    bit acc;
    int d;
    @(posedge clk);
    acc = load && m_ready;
    if (k % FRAME == FRAME - 1 && !m_ready) begin
      m_disp = m_pend;
      m_ready = 1'b1;
    end
    if (acc) begin
      m_pend = value_in;
      m_ready = 1'b0;
    end
    k++;
    if (k % SCAN_DIV != 0) begin
      d = (k / SCAN_DIV) % 4;
      m_bcd = (nib(m_disp, d) > 4'd9) ? 4'h0 : nib(m_disp, d);
    end
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [15:0] v);
    int n;
    n = 0;
    while (!m_ready && n < 64) begin
      step();
      n++;
    end
    load = 1'b1;
    value_in = v;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    load = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (got() !== {1'b1, 1'b0, 4'hF, 4'h0}) begin
      n_err++;
      $display("FAIL reset_state got %b required %b", got(),
               {1'b1, 1'b0, 4'hF, 4'h0});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      n_cmp++;
      if (got() !== expv()) begin
        n_err++;
        $display("FAIL idle_scan k=%0d got %b required %b", k, got(), expv());
      end
      step();
    end
  endtask

  task automatic test_load_and_ignore();
    int n;
    n = 0;
    while (!((k / SCAN_DIV) % 4 == 1 && m_ready) && n < 64) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= 64) begin
      n_err++;
      $display("FAIL load_wait got timeout required slot 1");
    end
    load = 1'b1;
    value_in = 16'h1234;
    step();
    value_in = 16'h5678;
    for (int i = 0; i < 3 * FRAME; i++) begin
      load = !m_ready;
      n_cmp++;
      if (got() !== expv()) begin
        n_err++;
        $display("FAIL load_1234 k=%0d got %b required %b", k, got(), expv());
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_invalid_digit();
    drive_load(16'h9A05);
    for (int i = 0; i < 3 * FRAME; i++) begin
      n_cmp++;
      if (got() !== expv()) begin
        n_err++;
        $display("FAIL invalid_9A05 k=%0d got %b required %b", k, got(), expv());
      end
      step();
    end
  endtask

  task automatic test_blank();
    drive_load(16'h0070);
    for (int i = 0; i < 3 * FRAME; i++) begin
      n_cmp++;
      if (got() !== expv()) begin
        n_err++;
        $display("FAIL blank_0070 k=%0d got %b required %b", k, got(), expv());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      n_cmp++;
      if (got() !== expv()) begin
        n_err++;
        $display("FAIL random k=%0d got %b required %b", k, got(), expv());
      end
      load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) value_in = 16'($urandom_range(0, 255));
      else value_in = 16'($urandom);
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_load(16'h8421);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (got() !== {1'b1, 1'b0, 4'hF, 4'h0}) begin
      n_err++;
      $display("FAIL reset_mid got %b required %b", got(),
               {1'b1, 1'b0, 4'hF, 4'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      n_cmp++;
      if (got() !== expv()) begin
        n_err++;
        $display("FAIL after_reset k=%0d got %b required %b", k, got(), expv());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_and_ignore();
    test_invalid_digit();
    test_blank();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
